sgd_model_wr_burst: RTL and testbench
=====================================

Name: sgd_model_wr_burst

Overview:
- Downstream neighbour of the model write-back reader in the SGD engine.
- Accepts one write command per epoch (start/addr/length) plus a 512-bit model data stream with almost-full backpressure.
- Buffers the stream and splits each command into 4 KB-boundary-safe bursts.
- Drives the memory write interface: a command channel and a data channel, both valid/ready, with `last` marking the end of each burst.

Parameters:
- FIFO_DEPTH, 64: data buffer depth in 512-bit beats. Must be a power of 2.
- AF_THRESH, 48: FIFO count at or above which `in_almost_full` asserts.
- MAX_BURST_BYTES, 4096: maximum burst size and boundary alignment. Must be a power of 2 and at least 64.

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_start  in  1  one-cycle pulse; latch cmd_addr and cmd_length
- cmd_addr  in  64  byte address; bits [5:0] ignored (treated as 0)
- cmd_length  in  32  byte count
- in_data  in  512  model data beat
- in_valid  in  1  beat valid; no ready signal; upstream obeys in_almost_full
- in_almost_full  out  1  registered backpressure to upstream
- m_cmd_valid  out  1  burst command valid
- m_cmd_ready  in  1  memory accepts command
- m_cmd_addr  out  64  burst byte address
- m_cmd_len  out  32  burst byte length, a multiple of 64
- m_data  out  512  write beat
- m_data_valid  out  1  beat valid
- m_data_ready  in  1  memory accepts beat
- m_data_last  out  1  final beat of the current burst
- busy  out  1  not IDLE, or a command is pending
- err_overflow  out  1  sticky: a beat was written while the FIFO was full
- err_cmd_drop  out  1  sticky: cmd_start arrived with the pending slot already full
- stat_bursts  out  32  bursts issued (optional feature)
- stat_beats  out  32  beats written (optional feature)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Flush the FIFO.
  - FSM goes to IDLE.
  - All outputs go to 0: valid signals, last, busy, both err flags, stats, addr/len.
  - A reset mid-burst abandons the burst; no further cycles are driven.
- Length handling: length_eff = (cmd_length + 63) & ~63. A command with length_eff == 0 is discarded and does not set busy.
- Command slot: one pending slot.
  - cmd_start while active and the slot is empty: store the command in the slot.
  - cmd_start while the slot is full: drop the command and set err_cmd_drop.
  - cmd_start in IDLE with the slot empty: load the command directly.
- FIFO input:
  - A write occurs on in_valid; the beat is written to the FIFO.
  - If the FIFO is full, drop the beat and set err_overflow.
  - in_almost_full is registered: it goes high the cycle after count >= AF_THRESH.
  - The slack FIFO_DEPTH-AF_THRESH (16) covers the upstream pipeline delay.
- FSM states and transitions:
  - IDLE:
    - If a command is available (the slot first, else cmd_start), load cur_addr and remaining.
    - Go to SPLIT.
  - SPLIT (1 cycle):
    - to_bound = MAX_BURST_BYTES - (cur_addr mod MAX_BURST_BYTES).
    - blen = min(remaining, to_bound).
    - Register m_cmd_addr = cur_addr and m_cmd_len = blen.
    - beats = blen/64.
    - Go to ISSUE.
  - ISSUE:
    - m_cmd_valid=1, with addr/len held stable until m_cmd_ready.
    - On the handshake: cur_addr += blen, remaining -= blen, go to DATA.
  - DATA:
    - m_data_valid = FIFO not empty; m_data = FIFO head (first-word-fall-through).
    - Pop on valid & ready.
    - m_data_last=1 when beat_cnt == beats-1.
    - On a last handshake: if remaining == 0, go to IDLE (or load the slot directly into SPLIT); else go to SPLIT.
- Data arriving before its command stays buffered; no beat is sent outside DATA.
- Simultaneous FIFO push and pop in one cycle: count unchanged.
- Arithmetic: 64-bit address add wraps modulo 2^64. remaining is 32-bit and never underflows, since blen <= remaining.

Optional Feature:
- SGD_WR_BURST_STATS_EN defined:
  - stat_bursts increments on each m_cmd handshake.
  - stat_beats increments on each m_data handshake.
  - Both are 32-bit, wrap, and clear on reset.
- Not defined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Package sgd_wr_pkg:
  - wr_state_t enum: IDLE, SPLIT, ISSUE, DATA.
  - BEAT_BYTES = 64.
  - BEAT_SHIFT = 6.
- Sub-module sgd_sync_fifo:
  - Synchronous FWFT FIFO, width 512, depth parameter.
  - Ports: wr_en, rd_en, full, empty, count.

Test Plan:
- cmd addr=0x1000, len=8192; 128 beats streamed; ready always 1 -> two commands (0x1000/4096, 0x2000/4096), 64 beats each, last on beats 63 and 127.
- cmd addr=0x1800, len=8192 -> bursts 0x1800/2048, 0x2000/4096, 0x3000/2048; beat counts 32, 64, 32.
- len=100 -> a single burst of 128 bytes, 2 beats; len=0 -> no command, busy stays 0.
- m_data_ready=0 while 60 beats are pushed -> in_almost_full rises the cycle after count reaches 48, err_overflow stays 0; 65 pushes with no pops -> err_overflow=1.
- Second cmd_start during DATA is stored and runs after the first completes; a third cmd_start while the slot is full -> err_cmd_drop=1.
- rst_n low for 1 cycle mid-DATA -> all outputs 0 the next cycle, FIFO empty; a new cmd afterwards completes normally. With SGD_WR_BURST_STATS_EN, the first test ends with stat_bursts=2 and stat_beats=128.

Source files
------------

// File: rtl/sgd_wr_pkg.sv
// Shared types and constants for the SGD model write-burst path.
package sgd_wr_pkg;
   typedef enum logic [1:0] {IDLE, SPLIT, ISSUE, DATA} wr_state_t;

   localparam int BEAT_BYTES = 64;
   localparam int BEAT_SHIFT = 6;

   // Round a byte count up to whole 512-bit beats.
   function automatic logic [31:0] len_round(input logic [31:0] len);
      return (len + 32'(BEAT_BYTES - 1)) & ~32'(BEAT_BYTES - 1);
   endfunction
endpackage

// File: rtl/sgd_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on rd_data whenever !empty.
module sgd_sync_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_wr, do_rd;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/sgd_model_wr_burst.sv
// Buffers the model write-back stream and splits each command into boundary-safe write bursts.
// Optional counters stat_bursts/stat_beats are built only with SGD_WR_BURST_STATS_EN.
module sgd_model_wr_burst
   import sgd_wr_pkg::*;
#(
   parameter int FIFO_DEPTH      = 64,
   parameter int AF_THRESH       = 48,
   parameter int MAX_BURST_BYTES = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_start,
   input  logic [63:0]  cmd_addr,
   input  logic [31:0]  cmd_length,
   input  logic [511:0] in_data,
   input  logic         in_valid,
   output logic         in_almost_full,
   output logic         m_cmd_valid,
   input  logic         m_cmd_ready,
   output logic [63:0]  m_cmd_addr,
   output logic [31:0]  m_cmd_len,
   output logic [511:0] m_data,
   output logic         m_data_valid,
   input  logic         m_data_ready,
   output logic         m_data_last,
   output logic         busy,
   output logic         err_overflow,
   output logic         err_cmd_drop,
   output logic [31:0]  stat_bursts,
   output logic [31:0]  stat_beats
);
   localparam int CW      = $clog2(FIFO_DEPTH) + 1;
   localparam int BOUND_W = $clog2(MAX_BURST_BYTES);
   localparam int BW      = BOUND_W - BEAT_SHIFT + 1;

   wr_state_t      state;
   logic [63:0]    cur_addr, slot_addr, cmd_base;
   logic [31:0]    remaining, slot_len, cmd_len_eff, to_bound, blen;
   logic [BW-1:0]  beats, beat_cnt;
   logic           slot_vld, cmd_ok, data_hs;
   logic           fifo_full, fifo_empty;
   logic [CW-1:0]  fifo_count;
   logic [511:0]   head;

   sgd_sync_fifo #(.WIDTH(512), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (in_valid),
      .wr_data (in_data),
      .rd_en   (data_hs),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign cmd_len_eff  = len_round(cmd_length);
   assign cmd_ok       = cmd_start && (cmd_len_eff != '0);
   assign cmd_base     = cmd_addr & ~64'(BEAT_BYTES - 1);
   assign to_bound     = 32'(MAX_BURST_BYTES) - 32'(cur_addr[BOUND_W-1:0]);
   assign blen         = (remaining < to_bound) ? remaining : to_bound;

   assign m_data_valid = (state == DATA) && !fifo_empty;
   assign m_data_last  = (state == DATA) && (beat_cnt == beats - BW'(1));
   assign m_data       = m_data_valid ? head : '0;
   assign data_hs      = m_data_valid & m_data_ready;
   assign busy         = (state != IDLE) || slot_vld;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cur_addr       <= '0;
         remaining      <= '0;
         beats          <= '0;
         beat_cnt       <= '0;
         slot_vld       <= 1'b0;
         slot_addr      <= '0;
         slot_len       <= '0;
         m_cmd_valid    <= 1'b0;
         m_cmd_addr     <= '0;
         m_cmd_len      <= '0;
         in_almost_full <= 1'b0;
         err_overflow   <= 1'b0;
         err_cmd_drop   <= 1'b0;
      end else begin
         in_almost_full <= (fifo_count >= CW'(AF_THRESH));
         if (in_valid && fifo_full) err_overflow <= 1'b1;

         // A busy engine parks one command; anything beyond that is dropped.
         if (cmd_ok) begin
            if (slot_vld) begin
               err_cmd_drop <= 1'b1;
            end else if (state != IDLE) begin
               slot_vld  <= 1'b1;
               slot_addr <= cmd_base;
               slot_len  <= cmd_len_eff;
            end
         end

         case (state)
            IDLE: begin
               if (slot_vld) begin
                  cur_addr  <= slot_addr;
                  remaining <= slot_len;
                  slot_vld  <= 1'b0;
                  state     <= SPLIT;
               end else if (cmd_ok) begin
                  cur_addr  <= cmd_base;
                  remaining <= cmd_len_eff;
                  state     <= SPLIT;
               end
            end
            SPLIT: begin
               m_cmd_addr  <= cur_addr;
               m_cmd_len   <= blen;
               beats       <= BW'(blen >> BEAT_SHIFT);
               beat_cnt    <= '0;
               m_cmd_valid <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: begin
               if (m_cmd_ready) begin
                  m_cmd_valid <= 1'b0;
                  cur_addr    <= cur_addr + 64'(m_cmd_len);
                  remaining   <= remaining - m_cmd_len;
                  state       <= DATA;
               end
            end
            DATA: begin
               if (data_hs) begin
                  beat_cnt <= beat_cnt + BW'(1);
                  if (m_data_last) begin
                     if (remaining != '0) begin
                        state <= SPLIT;
                     end else if (slot_vld) begin
                        cur_addr  <= slot_addr;
                        remaining <= slot_len;
                        slot_vld  <= 1'b0;
                        state     <= SPLIT;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SGD_WR_BURST_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_bursts <= '0;
         stat_beats  <= '0;
      end else begin
         if (m_cmd_valid && m_cmd_ready) stat_bursts <= stat_bursts + 32'd1;
         if (data_hs)                    stat_beats  <= stat_beats + 32'd1;
      end
   end
`else
   assign stat_bursts = '0;
   assign stat_beats  = '0;
`endif
endmodule

// File: tb/tb_sgd_model_wr_burst.sv
// Directed scoreboard bench for sgd_model_wr_burst.
module tb_sgd_model_wr_burst;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_start = 1'b0;
   logic [63:0]  cmd_addr = '0;
   logic [31:0]  cmd_length = '0;
   logic [511:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_almost_full;
   logic         m_cmd_valid;
   logic         m_cmd_ready = 1'b1;
   logic [63:0]  m_cmd_addr;
   logic [31:0]  m_cmd_len;
   logic [511:0] m_data;
   logic         m_data_valid;
   logic         m_data_ready = 1'b1;
   logic         m_data_last;
   logic         busy;
   logic         err_overflow;
   logic         err_cmd_drop;
   logic [31:0]  stat_bursts;
   logic [31:0]  stat_beats;

   sgd_model_wr_burst dut (
      .clk(clk), .rst_n(rst_n), .cmd_start(cmd_start), .cmd_addr(cmd_addr),
      .cmd_length(cmd_length), .in_data(in_data), .in_valid(in_valid),
      .in_almost_full(in_almost_full), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len), .m_data(m_data),
      .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_last(m_data_last),
      .busy(busy), .err_overflow(err_overflow), .err_cmd_drop(err_cmd_drop),
      .stat_bursts(stat_bursts), .stat_beats(stat_beats)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int ncmd   = 0;
   int nbeat  = 0;
   int beat_id = 0;

   logic [63:0]  q_addr[$];
   logic [31:0]  q_len[$];
   logic         q_last[$];
   logic [511:0] q_data[$];

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [511:0] beat(input int id);
      logic [31:0] w;
      w = 32'hC0DE_0000 + 32'(id);
      return {16{w}};
   endfunction

   // Reference split: 64-byte rounding, then bursts that never cross a 4 KB line.
   task automatic model_cmd(input logic [63:0] a_in, input logic [31:0] l_in);
      logic [63:0] a;
      logic [32:0] left, room, b;
      a    = a_in & ~64'd63;
      left = ({1'b0, l_in} + 33'd63) & ~33'd63;
      left = {1'b0, left[31:0]};
      while (left != 0) begin
         room = 33'd4096 - 33'(a % 64'd4096);
         b    = (left < room) ? left : room;
         q_addr.push_back(a);
         q_len.push_back(b[31:0]);
         for (int k = 0; k < int'(b / 64); k++) q_last.push_back(k == int'(b / 64) - 1);
         a    = a + 64'(b);
         left = left - b;
      end
   endtask

   task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, input bit expect_run);
      cmd_addr = a;
      cmd_length = l;
      cmd_start = 1'b1;
      if (expect_run) model_cmd(a, l);
      @(posedge clk); #1;
      cmd_start = 1'b0;
   endtask

   task automatic push(input int n);
      for (int i = 0; i < n; i++) begin
         in_data  = beat(beat_id);
         in_valid = 1'b1;
         q_data.push_back(beat(beat_id));
         beat_id++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int c;
      c = 0;
      while ((q_data.size() != 0 || q_addr.size() != 0 || busy) && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      chk(tag, {32'(q_data.size()), 32'(q_addr.size()), busy}, '0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q_addr.delete(); q_len.delete(); q_last.delete(); q_data.delete();
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_cmdv"}, m_cmd_valid, 0);
      chk({tag, "_datv"}, m_data_valid, 0);
      chk({tag, "_last"}, m_data_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_errs"}, {err_overflow, err_cmd_drop, in_almost_full}, 0);
      chk({tag, "_addrlen"}, {m_cmd_addr, m_cmd_len}, 0);
      chk({tag, "_stats"}, {stat_bursts, stat_beats}, 0);
   endtask

   // Scoreboard consumer: handshakes are stable at the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_cmd_valid && m_cmd_ready) begin
            chk("cmd_expected", q_addr.size() != 0, 1);
            if (q_addr.size() != 0) begin
               chk("cmd_addr", m_cmd_addr, q_addr.pop_front());
               chk("cmd_len", m_cmd_len, q_len.pop_front());
            end
            ncmd++;
         end
         if (m_data_valid && m_data_ready) begin
            chk("beat_expected", q_data.size() != 0 && q_last.size() != 0, 1);
            if (q_data.size() != 0 && q_last.size() != 0) begin
               chk("beat_data", m_data, q_data.pop_front());
               chk("beat_last", m_data_last, q_last.pop_front());
            end
            nbeat++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, b0;
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Aligned 8 KB: two full 4 KB bursts.
      c0 = ncmd; b0 = nbeat;
      send_cmd(64'h1000, 32'd8192, 1);
      push(128);
      drain("t1_drain");
      chk("t1_ncmd", ncmd - c0, 2);
      chk("t1_nbeat", nbeat - b0, 128);
`ifdef SGD_WR_BURST_STATS_EN
      chk("t1_stat_bursts", stat_bursts, 2);
      chk("t1_stat_beats", stat_beats, 128);
`else
      chk("t1_stats_tied", {stat_bursts, stat_beats}, 0);
`endif

      // Misaligned start: 2 KB, 4 KB, 2 KB.
      c0 = ncmd; b0 = nbeat;
      send_cmd(64'h1800, 32'd8192, 1);
      push(128);
      drain("t2_drain");
      chk("t2_ncmd", ncmd - c0, 3);
      chk("t2_nbeat", nbeat - b0, 128);

      // Odd length rounds up to 2 beats; low address bits ignored.
      c0 = ncmd;
      send_cmd(64'h4000_0025, 32'd100, 1);
      push(2);
      drain("t3_drain");
      chk("t3_ncmd", ncmd - c0, 1);

      // Zero length is discarded.
      c0 = ncmd;
      send_cmd(64'h5000, 32'd0, 1);
      chk("t4_busy0", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_busy1", busy, 0);
      chk("t4_ncmd", ncmd - c0, 0);

      // Pending slot and command drop.
      c0 = ncmd;
      send_cmd(64'h0, 32'd256, 1);
      repeat (5) @(posedge clk);
      #1;
      send_cmd(64'h10000, 32'd128, 1);
      chk("t6_busy", busy, 1);
      chk("t6_nodrop", err_cmd_drop, 0);
      send_cmd(64'h20000, 32'd128, 0);
      chk("t6_drop", err_cmd_drop, 1);
      push(6);
      drain("t6_drain");
      chk("t6_ncmd", ncmd - c0, 2);

      // Backpressure with no command: almost-full timing and overflow.
      m_data_ready = 1'b0;
      for (int n = 1; n <= 65; n++) begin
         in_data  = beat(9000 + n);
         in_valid = 1'b1;
         @(posedge clk); #1;
         if (n == 48) chk("t5_af_low", in_almost_full, 0);
         if (n == 49) chk("t5_af_high", in_almost_full, 1);
         if (n == 60) chk("t5_no_beat_idle", m_data_valid, 0);
         if (n == 64) chk("t5_ovf_low", err_overflow, 0);
         if (n == 65) chk("t5_ovf_high", err_overflow, 1);
      end
      in_valid = 1'b0;
      do_reset();
      chk_idle_outs("t5_reset");

      // Reset mid-DATA abandons the burst and flushes buffered beats.
      send_cmd(64'h0, 32'd512, 1);
      push(3);
      repeat (2) @(posedge clk);
      #1;
      chk("t7_in_data", busy, 1);
      do_reset();
      chk_idle_outs("t7_reset");
      m_data_ready = 1'b1;
      c0 = ncmd; b0 = nbeat;
      send_cmd(64'h2000, 32'd128, 1);
      push(2);
      drain("t7_drain");
      chk("t7_ncmd", ncmd - c0, 1);
      chk("t7_nbeat", nbeat - b0, 2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
